// File: rtl/hash_display_sequencer_if.sv
// Handshake bundle between the hash display sequencer and its hasher / BCD datapath.
// The master side issues start pulses and operands; the slave side returns done pulses and results.
interface hash_display_sequencer_if #(
    parameter int W = 16
);
    logic         hash_start;
    logic [W-1:0] hash_in;
    logic         hash_done;
    logic [W-1:0] hash_out;
    logic         bcd_start;
    logic [W-1:0] bcd_bin;
    logic         bcd_done;
    logic [19:0]  bcd_digits;

    modport master (
        output hash_start, hash_in, bcd_start, bcd_bin,
        input  hash_done, hash_out, bcd_done, bcd_digits
    );

    modport slave (
        input  hash_start, hash_in, bcd_start, bcd_bin,
        output hash_done, hash_out, bcd_done, bcd_digits
    );
endinterface

// File: rtl/hash_display_sequencer.sv
// Control FSM for the student-ID hash display: on each 5 s tick it runs one hash
// iteration, converts the result to BCD and updates the five display digits.
module hash_display_sequencer #(
    parameter int W       = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                      sysclk,
    input  logic                      rst_n,
    input  logic                      tick_5s,
    input  logic                      button_out,
    input  logic [W-1:0]              student_id,
    hash_display_sequencer_if.master  dp,
    output logic [W-1:0]              cur_hash,
    output logic [3:0]                D5_out,
    output logic [3:0]                D4_out,
    output logic [3:0]                D3_out,
    output logic [3:0]                D2_out,
    output logic [3:0]                D1_out,
    output logic                      busy,
    output logic                      overrun
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [19:0]   DIGITS_ERR = {5{4'hE}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HASH_REQ  = 3'd1,
        ST_HASH_WAIT = 3'd2,
        ST_BCD_REQ   = 3'd3,
        ST_BCD_WAIT  = 3'd4,
        ST_ERR       = 3'd5
    } state_t;

    state_t        state_r,      state_s;
    logic [TW-1:0] timer_r,      timer_s;
    logic          pending_r,    pending_s;
    logic          overrun_r,    overrun_s;
    logic          seeded_r,     seeded_s;
    logic [W-1:0]  id_q_r,       id_q_s;
    logic [W-1:0]  cur_hash_r,   cur_hash_s;
    logic [W-1:0]  hash_in_r,    hash_in_s;
    logic          hash_start_r, hash_start_s;
    logic          bcd_start_r,  bcd_start_s;
    logic [19:0]   digits_r,     digits_s;
    logic          busy_r,       busy_s;

    logic          go_s;
    logic          seed_fresh_s;
    logic          in_flight_s;

    // Next-state, handshake and datapath-register decisions for the whole sequencer.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r;
        pending_s    = pending_r;
        overrun_s    = overrun_r;
        seeded_s     = seeded_r;
        id_q_s       = id_q_r;
        cur_hash_s   = cur_hash_r;
        hash_in_s    = hash_in_r;
        hash_start_s = 1'b0;
        bcd_start_s  = 1'b0;
        digits_s     = digits_r;

        go_s         = (tick_5s | pending_r) & button_out;
        seed_fresh_s = (!seeded_r) || (student_id != id_q_r);
        in_flight_s  = (state_r != ST_IDLE) && (state_r != ST_ERR);

        // One-deep tick queue: a second tick while one is pending is dropped and flagged.
        if (in_flight_s && tick_5s) begin
            if (pending_r) begin
                overrun_s = 1'b1;
            end else begin
                pending_s = 1'b1;
            end
        end else begin
            pending_s = pending_s;
        end

        case (state_r)
            ST_IDLE: begin
                if (go_s) begin
                    state_s      = ST_HASH_REQ;
                    pending_s    = 1'b0;
                    hash_start_s = 1'b1;
                    if (seed_fresh_s) begin
                        hash_in_s = student_id;
                        id_q_s    = student_id;
                        seeded_s  = 1'b1;
                    end else begin
                        hash_in_s = cur_hash_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HASH_REQ: begin
                state_s = ST_HASH_WAIT;
                timer_s = TW'(0);
            end
            ST_HASH_WAIT: begin
                // A done on the final timeout cycle still counts as a success.
                if (dp.hash_done) begin
                    cur_hash_s  = dp.hash_out;
                    state_s     = ST_BCD_REQ;
                    bcd_start_s = 1'b1;
                end else if (timer_r == TIMER_LAST) begin
                    state_s  = ST_ERR;
                    digits_s = DIGITS_ERR;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ST_BCD_REQ: begin
                state_s = ST_BCD_WAIT;
                timer_s = TW'(0);
            end
            ST_BCD_WAIT: begin
                if (dp.bcd_done) begin
                    digits_s = dp.bcd_digits;
                    state_s  = ST_IDLE;
                end else if (timer_r == TIMER_LAST) begin
                    state_s  = ST_ERR;
                    digits_s = DIGITS_ERR;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ST_ERR: begin
                digits_s = DIGITS_ERR;
                if (!button_out) begin
                    state_s   = ST_IDLE;
                    seeded_s  = 1'b0;
                    pending_s = 1'b0;
                end else begin
                    state_s = ST_ERR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE) && (state_s != ST_ERR);
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            timer_r      <= TW'(0);
            pending_r    <= 1'b0;
            overrun_r    <= 1'b0;
            seeded_r     <= 1'b0;
            id_q_r       <= {W{1'b0}};
            cur_hash_r   <= {W{1'b0}};
            hash_in_r    <= {W{1'b0}};
            hash_start_r <= 1'b0;
            bcd_start_r  <= 1'b0;
            digits_r     <= 20'h00000;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            pending_r    <= pending_s;
            overrun_r    <= overrun_s;
            seeded_r     <= seeded_s;
            id_q_r       <= id_q_s;
            cur_hash_r   <= cur_hash_s;
            hash_in_r    <= hash_in_s;
            hash_start_r <= hash_start_s;
            bcd_start_r  <= bcd_start_s;
            digits_r     <= digits_s;
            busy_r       <= busy_s;
        end
    end

    assign dp.hash_start = hash_start_r;
    assign dp.hash_in    = hash_in_r;
    assign dp.bcd_start  = bcd_start_r;
    assign dp.bcd_bin    = cur_hash_r;
    assign cur_hash      = cur_hash_r;
    assign D5_out        = digits_r[19:16];
    assign D4_out        = digits_r[15:12];
    assign D3_out        = digits_r[11:8];
    assign D2_out        = digits_r[7:4];
    assign D1_out        = digits_r[3:0];
    assign busy          = busy_r;
    assign overrun       = overrun_r;

endmodule
